// File: rtl/rx_serial_7o1_if.sv
// Signal bundle for the 7O1 serial receiver: serial line in, character and debug flags out.
interface rx_serial_7o1_if;
  logic       dado_serial;
  logic [6:0] dados_ascii;
  logic       paridade_ok;
  logic       pronto;
  logic       erro_parada;
  logic       db_clock;
  logic       db_tick;
  logic       db_dado_serial;
  logic [3:0] db_estado;

  modport master (
    output dado_serial,
    input  dados_ascii, paridade_ok, pronto, erro_parada,
    input  db_clock, db_tick, db_dado_serial, db_estado
  );

  modport slave (
    input  dado_serial,
    output dados_ascii, paridade_ok, pronto, erro_parada,
    output db_clock, db_tick, db_dado_serial, db_estado
  );
endinterface

// File: rtl/rx_serial_7o1.sv
// UART-style receiver for 7 data bits, odd parity, one stop bit; samples each bit mid-period.
module rx_serial_7o1 #(
  parameter int CLK_POR_BIT = 434
) (
  input logic            clock,
  input logic            reset,
  rx_serial_7o1_if.slave bus
);
  localparam int HALF = CLK_POR_BIT / 2;
  localparam int CW   = $clog2(CLK_POR_BIT);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLK_POR_BIT - 1);

  localparam logic [3:0] ESPERA_ALTO = 4'd0;
  localparam logic [3:0] OCIOSO      = 4'd1;
  localparam logic [3:0] START       = 4'd2;
  localparam logic [3:0] RECEBE      = 4'd3;
  localparam logic [3:0] FINAL       = 4'd4;
  localparam logic [3:0] ERRO        = 4'd5;

  // 1 when data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] v);
    return ^v;
  endfunction

  logic          sync1_r, sync2_r;
  logic [3:0]    state_r, state_nx_s;
  logic [CW-1:0] cnt_r, cnt_nx_s;
  logic [3:0]    idx_r, idx_nx_s;
  logic [8:0]    shift_r, shift_nx_s;
  logic          tick_r, tick_nx_s;
  logic [6:0]    dados_r;
  logic          par_ok_r, pronto_r, erro_r;
  logic          rx_s;

  assign rx_s = sync2_r;

  // Next-state, bit timing and shift register control.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    idx_nx_s   = idx_r;
    shift_nx_s = shift_r;
    case (state_r)
      ESPERA_ALTO, ERRO: begin
        if (rx_s) state_nx_s = OCIOSO;
        else      state_nx_s = state_r;
      end
      OCIOSO: begin
        if (!rx_s) begin
          state_nx_s = START;
          cnt_nx_s   = {CW{1'b0}};
        end else begin
          state_nx_s = OCIOSO;
        end
      end
      START: begin
        if (cnt_r == CNT_HALF) begin
          if (!rx_s) begin
            state_nx_s = RECEBE;
            cnt_nx_s   = {CW{1'b0}};
            idx_nx_s   = 4'd0;
          end else begin
            state_nx_s = OCIOSO;
          end
        end else begin
          cnt_nx_s = cnt_r + CW'(1);
        end
      end
      RECEBE: begin
        if (cnt_r == CNT_FULL) begin
          cnt_nx_s   = {CW{1'b0}};
          shift_nx_s = {rx_s, shift_r[8:1]};
          idx_nx_s   = idx_r + 4'd1;
          // Ninth sample is the stop bit.
          if (idx_r == 4'd8) state_nx_s = rx_s ? FINAL : ERRO;
          else               state_nx_s = RECEBE;
        end else begin
          cnt_nx_s = cnt_r + CW'(1);
        end
      end
      FINAL:   state_nx_s = OCIOSO;
      default: state_nx_s = ESPERA_ALTO;
    endcase
  end

  // Strobe is precomputed so the registered copy lines up with the sample cycle.
  always_comb begin
    tick_nx_s = ((state_nx_s == START)  && (cnt_nx_s == CNT_HALF)) ||
                ((state_nx_s == RECEBE) && (cnt_nx_s == CNT_FULL));
  end

  // Line synchronizer, control state and registered character outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r  <= 1'b1;
      sync2_r  <= 1'b1;
      state_r  <= ESPERA_ALTO;
      cnt_r    <= {CW{1'b0}};
      idx_r    <= 4'd0;
      shift_r  <= 9'd0;
      tick_r   <= 1'b0;
      dados_r  <= 7'd0;
      par_ok_r <= 1'b0;
      pronto_r <= 1'b0;
      erro_r   <= 1'b0;
    end else begin
      sync1_r  <= bus.dado_serial;
      sync2_r  <= sync1_r;
      state_r  <= state_nx_s;
      cnt_r    <= cnt_nx_s;
      idx_r    <= idx_nx_s;
      shift_r  <= shift_nx_s;
      tick_r   <= tick_nx_s;
      pronto_r <= (state_nx_s == FINAL);
      if (state_nx_s == FINAL) begin
        dados_r  <= shift_nx_s[6:0];
        par_ok_r <= odd_parity(shift_nx_s[7:0]);
        erro_r   <= 1'b0;
      end else if (state_nx_s == ERRO) begin
        erro_r   <= 1'b1;
      end else begin
        erro_r   <= erro_r;
      end
    end
  end

  assign bus.dados_ascii    = dados_r;
  assign bus.paridade_ok    = par_ok_r;
  assign bus.pronto         = pronto_r;
  assign bus.erro_parada    = erro_r;
  assign bus.db_clock       = clock;
  assign bus.db_tick        = tick_r;
  assign bus.db_dado_serial = sync2_r;
  assign bus.db_estado      = state_r;
endmodule

// File: doc/rx_serial_7o1.md
RX_SERIAL_7O1 -- requirements
Module: rx_serial_7O1

Interface
REQ-001 Parameter CLK_POR_BIT, default 434, clocks per bit period (50 MHz / 115200 baud); half period = CLK_POR_BIT/2 (integer division, 217).
REQ-002 clock  in  1  system clock; all state changes on its rising edge.
REQ-003 reset  in  1  reset; one clock, reset is synchronous and active-high.
REQ-004 dado_serial  in  1  asynchronous serial line, idle high, format 7O1 (start 0, 7 data bits LSB first, odd parity, 1 stop).
REQ-005 dados_ascii  out  7  last correctly framed character.
REQ-006 paridade_ok  out  1  1 = parity of the character in dados_ascii was odd (correct).
REQ-007 pronto  out  1  one-clock pulse: new character in dados_ascii.
REQ-008 erro_parada  out  1  stop-bit (framing) error flag.
REQ-009 db_clock, db_tick, db_dado_serial  out  1 each  debug copies: clock, sample strobe, synchronized line.
REQ-010 db_estado  out  4  current state code (REQ-013).

Function
REQ-011 dado_serial SHALL pass through a 2-flop synchronizer (flops reset to 1); all logic uses the synchronized value "rx".
REQ-012 One bit-timing counter, 0..CLK_POR_BIT-1, zeroed on every state entry into START or RECEBE.
REQ-013 States/codes: ESPERA_ALTO=0, OCIOSO=1, START=2, RECEBE=3, FINAL=4, ERRO=5; unused codes SHALL go to ESPERA_ALTO.
REQ-014 ESPERA_ALTO: rx=1 -> OCIOSO; else stay (line held low is never taken as a start).
REQ-015 OCIOSO: rx=0 -> START; else stay.
REQ-016 START: at counter = CLK_POR_BIT/2-1 sample rx; rx=0 -> RECEBE (bit index 0); rx=1 -> OCIOSO (false start, no outputs change).
REQ-017 RECEBE: each time counter = CLK_POR_BIT-1, sample rx into 9-bit shift register (data0..6, parity, stop), index+1, counter wraps to 0.
REQ-018 After the 9th sample (stop bit): stop=1 -> FINAL; stop=0 -> ERRO.
REQ-019 db_tick SHALL be 1 exactly on each of the 10 sample cycles (start check + 9 bits).
REQ-020 FINAL (exactly one cycle): pronto=1; dados_ascii <= data bits; paridade_ok <= XOR(data0..6, parity); erro_parada <= 0; -> OCIOSO.
REQ-021 ERRO: erro_parada=1, dados_ascii/paridade_ok unchanged, no pronto; behaves as ESPERA_ALTO (wait rx=1 -> OCIOSO).
REQ-022 erro_parada SHALL stay 1 until next FINAL or reset.
REQ-023 Latency: START-entry to stop sample = CLK_POR_BIT/2 + 9*CLK_POR_BIT cycles (4123 at default); pronto the next cycle; +2 cycles synchronizer delay from pin.
REQ-024 Back-to-back frames: a start bit directly after the stop bit SHALL be received without loss (OCIOSO reached mid stop bit).
REQ-025 Parity error SHALL NOT block reception: character delivered with paridade_ok=0.

Reset
REQ-026 reset=1 at a clock edge SHALL, regardless of state: state=ESPERA_ALTO, counters/index/shift register=0, synchronizer=1, dados_ascii=0, paridade_ok=0, pronto=0, erro_parada=0, db_estado=0.
REQ-027 Reset mid-frame SHALL discard the frame; reception resumes only after rx seen high.

Verification
REQ-028 Reset, send 0x41 (data 1000001 LSB first, parity 1, stop 1) -> one pronto pulse 4123+2 cycles after falling edge (+1), dados_ascii=0x41, paridade_ok=1.
REQ-029 Send 0x41 with parity 0 -> pronto pulse, dados_ascii=0x41, paridade_ok=0.
REQ-030 100-cycle low glitch in OCIOSO -> START then back to OCIOSO, db_tick once, no pronto, outputs unchanged.
REQ-031 Send 0x33 with stop bit 0, hold line low 1000 cycles -> erro_parada=1, db_estado=5 until line high, no pronto, dados_ascii keeps previous value.
REQ-032 Assert reset during data bit 3 -> next cycle all outputs reset values, db_estado=0; following clean 0x2A frame -> dados_ascii=0x2A, paridade_ok=1.
REQ-033 0x55 (parity 1) then 0x2A (parity 0) with no idle gap -> two pronto pulses, 0x55 then 0x2A, paridade_ok=1 both.
